// File: rtl/imem_prog_if.sv
// ---------------------------------------------------------------------------
// imem_prog_if : program-download channel between the boot/test loader and
//                the writable instruction memory (imem_prog).
//
// Signals
//   ld_start  loader -> imem  begin a download at ld_base (honoured in IDLE)
//   ld_base   loader -> imem  first write address of the download
//   ld_valid  loader -> imem  ld_data carries a word
//   ld_data   loader -> imem  instruction word to store
//   ld_last   loader -> imem  marks the final word of the download
//   ld_ready  imem -> loader  memory is accepting words (high while loading)
//   ld_done   imem -> loader  one-cycle pulse after the last word is stored
//
// Modports
//   master : the loader side
//   slave  : the memory side
// ---------------------------------------------------------------------------
interface imem_prog_if #(
  parameter int IW = 9,
  parameter int AW = 8
) ();

  logic          ld_start;
  logic [AW-1:0] ld_base;
  logic          ld_valid;
  logic [IW-1:0] ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic          ld_done;

  modport master (
    output ld_start,
    output ld_base,
    output ld_valid,
    output ld_data,
    output ld_last,
    input  ld_ready,
    input  ld_done
  );

  modport slave (
    input  ld_start,
    input  ld_base,
    input  ld_valid,
    input  ld_data,
    input  ld_last,
    output ld_ready,
    output ld_done
  );

endinterface

// File: rtl/imem_prog.sv
// ---------------------------------------------------------------------------
// imem_prog : writable instruction memory holding several programs.
//
// A DEPTH = 2**AW word RAM is filled by a streamed download over the ld
// channel and read by the PC/control unit with a registered one-cycle fetch.
// Each program starts at an entry of an NPROG-entry base table; the fetch
// address is base[prog_sel] + PC, wrapped to AW bits.
//
// Ports
//   Clk         clock, all state changes on the rising edge
//   Reset_n     asynchronous active-low reset (RAM contents are kept)
//   ld          imem_prog_if.slave download channel
//   base_we     write base[base_sel] <= base_val on the edge
//   base_sel    base table entry to write
//   base_val    start address to write
//   prog_sel    active program (selects the base table entry for fetches)
//   fetch_en    fetch request this cycle
//   PC          program-relative instruction index
//   iptr        fetched instruction (registered)
//   iptr_valid  iptr holds the result of last cycle's fetch
//   fault       sticky error flag (load wrap, fetch wrap, fetch during load,
//               parity mismatch)
//   fault_clr   clear fault; a simultaneous new fault event wins
//   parity_err  parity mismatch on the word in iptr
//
// Optional feature: define IMEM_PARITY_EN to store an even-parity bit with
// every word and check it on fetch. Without it parity_err is tied 0 and the
// RAM is IW bits wide.
// ---------------------------------------------------------------------------
module imem_prog #(
  parameter int   IW    = 9,
  parameter int   AW    = 8,
  parameter int   NPROG = 4,
  localparam int  PW    = (NPROG > 1) ? $clog2(NPROG) : 1
) (
  input  logic          Clk,
  input  logic          Reset_n,
  imem_prog_if.slave    ld,
  input  logic          base_we,
  input  logic [PW-1:0] base_sel,
  input  logic [AW-1:0] base_val,
  input  logic [PW-1:0] prog_sel,
  input  logic          fetch_en,
  input  logic [AW-1:0] PC,
  output logic [IW-1:0] iptr,
  output logic          iptr_valid,
  output logic          fault,
  input  logic          fault_clr,
  output logic          parity_err
);

  localparam int DEPTH = 2 ** AW;
`ifdef IMEM_PARITY_EN
  localparam int RW = IW + 1;
`else
  localparam int RW = IW;
`endif

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOAD = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          ld_done_q, ld_done_d;
  logic [IW-1:0] iptr_q, iptr_d;
  logic          iptr_valid_q, iptr_valid_d;
  logic          fault_q, fault_d;
  logic          parity_err_q, parity_err_d;
  logic [AW-1:0] base_q [NPROG];
  logic [AW-1:0] base_d [NPROG];

  logic [RW-1:0] mem [DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [RW-1:0] mem_wdata;

  logic [AW-1:0] base_rd;
  logic [AW:0]   fetch_sum;
  logic [RW-1:0] rdata;
  logic          fault_set;

`ifdef IMEM_PARITY_EN
  // Even parity: the stored bit makes the total number of ones even.
  function automatic logic even_par(input logic [IW-1:0] w);
    return ^w;
  endfunction
`endif

  // Fetch address: the extra MSB of the sum is the wrap (carry) indicator.
  always_comb begin
    base_rd   = base_q[prog_sel];
    fetch_sum = {1'b0, base_rd} + {1'b0, PC};
    rdata     = mem[fetch_sum[AW-1:0]];
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    ld_done_d    = 1'b0;
    iptr_d       = iptr_q;
    iptr_valid_d = 1'b0;
    parity_err_d = 1'b0;
    base_d       = base_q;
    mem_we       = 1'b0;
    mem_waddr    = ptr_q;
    mem_wdata    = '0;
    fault_set    = 1'b0;

    // The base table is writable in either state; a fetch in the same cycle
    // still sees the old entry because the read above uses base_q.
    if (base_we) begin
      base_d[base_sel] = base_val;
    end

    case (state_q)
      S_IDLE: begin
        if (ld.ld_start) begin
          state_d = S_LOAD;
          ptr_d   = ld.ld_base;
        end
        if (fetch_en) begin
          iptr_d       = rdata[IW-1:0];
          iptr_valid_d = 1'b1;
          if (fetch_sum[AW]) begin
            fault_set = 1'b1;
          end
`ifdef IMEM_PARITY_EN
          if (even_par(rdata[IW-1:0]) != rdata[IW]) begin
            parity_err_d = 1'b1;
            fault_set    = 1'b1;
          end
`endif
        end
      end

      S_LOAD: begin
        // ld_ready is 1 throughout LOAD, so ld_valid alone is the accept.
        if (ld.ld_valid) begin
          mem_we = 1'b1;
`ifdef IMEM_PARITY_EN
          mem_wdata = {even_par(ld.ld_data), ld.ld_data};
`else
          mem_wdata = ld.ld_data;
`endif
          ptr_d = ptr_q + AW'(1);
          if (ld.ld_last) begin
            state_d   = S_IDLE;
            ld_done_d = 1'b1;
          end else if (ptr_q == {AW{1'b1}}) begin
            // More words follow the top address: the download wrapped.
            fault_set = 1'b1;
          end
        end
        // Fetches are refused while the RAM is being written; the NOP
        // encoding (0) is returned and the attempt is flagged.
        if (fetch_en) begin
          iptr_d       = '0;
          iptr_valid_d = 1'b0;
          fault_set    = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    fault_d = fault_set | (fault_q & ~fault_clr);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      ld_done_q    <= 1'b0;
      iptr_q       <= '0;
      iptr_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      parity_err_q <= 1'b0;
      for (int i = 0; i < NPROG; i++) begin
        base_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      ld_done_q    <= ld_done_d;
      iptr_q       <= iptr_d;
      iptr_valid_q <= iptr_valid_d;
      fault_q      <= fault_d;
      parity_err_q <= parity_err_d;
      base_q       <= base_d;
    end
  end

  // RAM array: no reset, contents survive Reset_n.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign ld.ld_ready = (state_q == S_LOAD);
  assign ld.ld_done  = ld_done_q;
  assign iptr        = iptr_q;
  assign iptr_valid  = iptr_valid_q;
  assign fault       = fault_q;
`ifdef IMEM_PARITY_EN
  assign parity_err  = parity_err_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_imem_prog.sv
module tb_imem_prog;

  localparam int IW    = 9;
  localparam int AW    = 8;
  localparam int NPROG = 4;
  localparam int PW    = 2;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          base_we;
  logic [PW-1:0] base_sel;
  logic [AW-1:0] base_val;
  logic [PW-1:0] prog_sel;
  logic          fetch_en;
  logic [AW-1:0] PC;
  logic [IW-1:0] iptr;
  logic          iptr_valid;
  logic          fault;
  logic          fault_clr;
  logic          parity_err;

  always #5 Clk = ~Clk;

  imem_prog_if #(.IW(IW), .AW(AW)) ld_if ();

  imem_prog #(.IW(IW), .AW(AW), .NPROG(NPROG)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .ld         (ld_if.slave),
    .base_we    (base_we),
    .base_sel   (base_sel),
    .base_val   (base_val),
    .prog_sel   (prog_sel),
    .fetch_en   (fetch_en),
    .PC         (PC),
    .iptr       (iptr),
    .iptr_valid (iptr_valid),
    .fault      (fault),
    .fault_clr  (fault_clr),
    .parity_err (parity_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Expected fetch results as {parity_err, iptr}.
  logic [IW:0] exp_q[$];
  logic [IW:0] mon_e;
  logic [IW-1:0] words [8];

  // Scoreboard monitor: every valid fetch result is popped and compared.
  always @(negedge Clk) begin
    if (Reset_n === 1'b1 && iptr_valid === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_fetch: got iptr=0x%0h with no fetch outstanding", iptr);
      end else begin
        mon_e = exp_q.pop_front();
        if ({parity_err, iptr} !== mon_e) begin
          n_err++;
          $display("FAIL fetch_result: got perr=%0b iptr=0x%0h, expected perr=%0b iptr=0x%0h",
                   parity_err, iptr, mon_e[IW], mon_e[IW-1:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_base(input logic [PW-1:0] sel, input logic [AW-1:0] val);
    base_we  = 1'b1;
    base_sel = sel;
    base_val = val;
    tick();
    base_we  = 1'b0;
  endtask

  task automatic fetch(input logic [PW-1:0] p, input logic [AW-1:0] pc, input logic [IW:0] e);
    prog_sel = p;
    PC       = pc;
    fetch_en = 1'b1;
    exp_q.push_back(e);
    tick();
    fetch_en = 1'b0;
  endtask

  // Download words[0..n-1] at base; gap inserts an idle cycle before each word.
  task automatic do_load(input logic [AW-1:0] base, input int n, input bit gap);
    int dones = 0;
    ld_if.ld_start = 1'b1;
    ld_if.ld_base  = base;
    tick();
    ld_if.ld_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gap) begin
        ld_if.ld_valid = 1'b0;
        chk("ld_ready_gap", 32'(ld_if.ld_ready), 32'd1);
        tick();
        if (ld_if.ld_done) dones++;
      end
      chk("ld_ready_word", 32'(ld_if.ld_ready), 32'd1);
      ld_if.ld_valid = 1'b1;
      ld_if.ld_data  = words[i];
      ld_if.ld_last  = (i == n - 1);
      tick();
      if (ld_if.ld_done) dones++;
    end
    ld_if.ld_valid = 1'b0;
    ld_if.ld_last  = 1'b0;
    chk("ld_done_after_last", 32'(ld_if.ld_done), 32'd1);
    chk("ld_ready_idle", 32'(ld_if.ld_ready), 32'd0);
    tick();
    if (ld_if.ld_done) dones++;
    chk("ld_done_pulses", 32'(dones), 32'd1);
  endtask

  initial begin
    ld_if.ld_start = 1'b0;
    ld_if.ld_base  = '0;
    ld_if.ld_valid = 1'b0;
    ld_if.ld_data  = '0;
    ld_if.ld_last  = 1'b0;
    base_we   = 1'b0;
    base_sel  = '0;
    base_val  = '0;
    prog_sel  = '0;
    fetch_en  = 1'b0;
    PC        = '0;
    fault_clr = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_iptr", 32'(iptr), 32'd0);
    chk("rst_iptr_valid", 32'(iptr_valid), 32'd0);
    chk("rst_ld_ready", 32'(ld_if.ld_ready), 32'd0);
    chk("rst_ld_done", 32'(ld_if.ld_done), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_parity_err", 32'(parity_err), 32'd0);
    #2 Reset_n = 1'b1;
    tick();

    // Download at 25 with ld_valid toggling, then fetch from program 1
    words[0] = 9'h019; words[1] = 9'h01A; words[2] = 9'h01B;
    words[3] = 9'h01C; words[4] = 9'h01D;
    do_load(8'd25, 5, 1'b1);
    set_base(2'd1, 8'd25);
    fetch(2'd1, 8'd3, {1'b0, 9'h01C});
    fetch(2'd1, 8'd0, {1'b0, 9'h019});
    fetch(2'd1, 8'd4, {1'b0, 9'h01D});
    tick();
    chk("idle_valid_drop", 32'(iptr_valid), 32'd0);
    chk("idle_iptr_hold", 32'(iptr), 32'h01D);
    chk("fault_pre_wrap", 32'(fault), 32'd0);

    // Load wrap: 254, 255, 0
    words[0] = 9'h0A1; words[1] = 9'h0A2; words[2] = 9'h0A3;
    do_load(8'd254, 3, 1'b0);
    chk("wrap_fault", 32'(fault), 32'd1);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("wrap_fault_clr", 32'(fault), 32'd0);

    words[0] = 9'h104;
    do_load(8'd4, 1, 1'b0);
    words[0] = 9'h12C; words[1] = 9'h12D;
    do_load(8'd44, 2, 1'b0);

    // Wrapped words readable; carry out of the sum flags fault
    set_base(2'd2, 8'd254);
    fetch(2'd2, 8'd1, {1'b0, 9'h0A2});
    chk("no_carry_fault", 32'(fault), 32'd0);
    fetch(2'd2, 8'd2, {1'b0, 9'h0A3});
    chk("carry_fault", 32'(fault), 32'd1);

    // Overflow fetch 250+10 -> RAM[4]; set wins over fault_clr
    set_base(2'd3, 8'd250);
    fault_clr = 1'b1;
    fetch(2'd3, 8'd10, {1'b0, 9'h104});
    chk("set_beats_clr", 32'(fault), 32'd1);
    tick();
    fault_clr = 1'b0;
    chk("fault_cleared", 32'(fault), 32'd0);
    fetch(2'd3, 8'd10, {1'b0, 9'h104});
    chk("overflow_fault", 32'(fault), 32'd1);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;

    // Same-cycle base write: old base (0) used, new one next fetch
    base_we  = 1'b1;
    base_sel = 2'd0;
    base_val = 8'd44;
    fetch(2'd0, 8'd0, {1'b0, 9'h0A3});
    base_we = 1'b0;
    fetch(2'd0, 8'd0, {1'b0, 9'h12C});
    fetch(2'd0, 8'd1, {1'b0, 9'h12D});
    chk("fault_pre_load_fetch", 32'(fault), 32'd0);

    // Fetch during LOAD
    ld_if.ld_start = 1'b1;
    ld_if.ld_base  = 8'd100;
    tick();
    ld_if.ld_start = 1'b0;
    prog_sel = 2'd0;
    PC       = 8'd0;
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    chk("load_fetch_iptr", 32'(iptr), 32'd0);
    chk("load_fetch_valid", 32'(iptr_valid), 32'd0);
    chk("load_fetch_fault", 32'(fault), 32'd1);
    chk("load_fetch_ready", 32'(ld_if.ld_ready), 32'd1);
    ld_if.ld_valid = 1'b1;
    ld_if.ld_data  = 9'h164;
    ld_if.ld_last  = 1'b1;
    tick();
    ld_if.ld_valid = 1'b0;
    ld_if.ld_last  = 1'b0;
    chk("load_fetch_done", 32'(ld_if.ld_done), 32'd1);
    tick();

    // Reset mid-download (fetch in the ld_start cycle still served)
    ld_if.ld_start = 1'b1;
    ld_if.ld_base  = 8'd120;
    prog_sel = 2'd0;
    PC       = 8'd0;
    fetch_en = 1'b1;
    exp_q.push_back({1'b0, 9'h12C});
    tick();
    ld_if.ld_start = 1'b0;
    fetch_en = 1'b0;
    ld_if.ld_valid = 1'b1;
    ld_if.ld_data  = 9'h1F0;
    ld_if.ld_last  = 1'b0;
    tick();
    ld_if.ld_data  = 9'h1F1;
    #2 Reset_n = 1'b0;
    #1;
    chk("arst_iptr", 32'(iptr), 32'd0);
    chk("arst_ld_ready", 32'(ld_if.ld_ready), 32'd0);
    chk("arst_fault", 32'(fault), 32'd0);
    chk("arst_ld_done", 32'(ld_if.ld_done), 32'd0);
    chk("arst_valid", 32'(iptr_valid), 32'd0);
    ld_if.ld_valid = 1'b0;
    #2 Reset_n = 1'b1;
    tick();
    chk("post_rst_idle", 32'(ld_if.ld_ready), 32'd0);
    set_base(2'd0, 8'd120);
    fetch(2'd0, 8'd0, {1'b0, 9'h1F0});

`ifdef IMEM_PARITY_EN
    // Parity: corrupt RAM[30] behind the memory's back
    words[0] = 9'h0F3; words[1] = 9'h0F4;
    do_load(8'd30, 2, 1'b0);
    dut.mem[30][0] = ~dut.mem[30][0];
    set_base(2'd1, 8'd30);
    chk("par_fault_pre", 32'(fault), 32'd0);
    fetch(2'd1, 8'd0, {1'b1, 9'h0F2});
    chk("par_fault", 32'(fault), 32'd1);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    fetch(2'd1, 8'd1, {1'b0, 9'h0F4});
    chk("par_clean_fault", 32'(fault), 32'd0);
`endif

    tick();
    tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
